// File: rtl/sseg_pkg.sv
// Seven-segment constants shared by the scan controller and its hex encoder.
// Patterns are active-high; bit 0..6 = segments a..g.
package sseg_pkg;

   localparam int unsigned SEG_A_BIT  = 0;
   localparam int unsigned SEG_B_BIT  = 1;
   localparam int unsigned SEG_C_BIT  = 2;
   localparam int unsigned SEG_D_BIT  = 3;
   localparam int unsigned SEG_E_BIT  = 4;
   localparam int unsigned SEG_F_BIT  = 5;
   localparam int unsigned SEG_G_BIT  = 6;
   localparam int unsigned SEG_DP_BIT = 7;

   localparam logic [6:0] SEG_OFF = 7'h00;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/sseg_hex_encoder.sv
// Combinational hex nibble to active-high seven-segment pattern.
module sseg_hex_encoder
   import sseg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segments
);

   // Full 16-entry lookup; output polarity is left to the caller.
   always_comb begin
      segments = SEG_OFF;
      unique case (nibble)
         4'h0: segments = SEG_0;
         4'h1: segments = SEG_1;
         4'h2: segments = SEG_2;
         4'h3: segments = SEG_3;
         4'h4: segments = SEG_4;
         4'h5: segments = SEG_5;
         4'h6: segments = SEG_6;
         4'h7: segments = SEG_7;
         4'h8: segments = SEG_8;
         4'h9: segments = SEG_9;
         4'hA: segments = SEG_A;
         4'hB: segments = SEG_B;
         4'hC: segments = SEG_C;
         4'hD: segments = SEG_D;
         4'hE: segments = SEG_E;
         4'hF: segments = SEG_F;
      endcase
   end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// N-digit multiplexed seven-segment scanner: clock-enable timebase, per-frame
// input snapshot, ghost blanking, PWM brightness, leading-zero suppression and
// configurable output polarity.
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned DIV_BITS       = 16,
   parameter int unsigned BRIGHT_W       = 4,
   parameter int unsigned BLANK_TICKS    = 64,
   parameter bit          SEL_ACTIVE_LOW = 1'b0,
   parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic                    blank_lz,
   input  logic [BRIGHT_W-1:0]     brightness,
   input  logic                    enable,
   output logic [NUM_DIGITS-1:0]   sseg_sel,
   output logic [7:0]              sseg_data,
   output logic                    frame_start
);

   localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [DIV_BITS-1:0]   BLANK_END  = DIV_BITS'(BLANK_TICKS);
   localparam logic [DIG_W-1:0]      DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] SEL_OFF    = {NUM_DIGITS{SEL_ACTIVE_LOW}};
   localparam logic [7:0]            DATA_OFF   = {8{SEG_ACTIVE_LOW}};

   logic [DIV_BITS-1:0]     tick_q, tick_d;
   logic [DIG_W-1:0]        digit_q, digit_d;

   logic [4*NUM_DIGITS-1:0] snap_value_q;
   logic [NUM_DIGITS-1:0]   snap_dp_q;
   logic                    snap_lz_q;
   logic [BRIGHT_W-1:0]     snap_bright_q;

   logic                    snap_take;
   logic [4*NUM_DIGITS-1:0] eff_value;
   logic [NUM_DIGITS-1:0]   eff_dp;
   logic                    eff_lz;
   logic [BRIGHT_W-1:0]     eff_bright;

   logic [3:0]              nibble;
   logic [6:0]              hex_seg;
   logic                    upper_nz;
   logic                    lz_suppress;
   logic [BRIGHT_W-1:0]     pwm_slice;
   logic                    lit;

   logic [NUM_DIGITS-1:0]   sel_d, sel_q;
   logic [7:0]              data_d, data_q;

   // A new frame begins whenever the scan sits at digit 0, tick 0 while enabled.
   assign snap_take   = enable && (tick_q == '0) && (digit_q == '0);
   assign frame_start = snap_take & ~rst;

   // During the snapshot cycle the registers still hold the previous frame, so
   // bypass the live inputs to keep the first slot consistent with its frame.
   assign eff_value  = snap_take ? value      : snap_value_q;
   assign eff_dp     = snap_take ? dp_mask    : snap_dp_q;
   assign eff_lz     = snap_take ? blank_lz   : snap_lz_q;
   assign eff_bright = snap_take ? brightness : snap_bright_q;

   // Timebase next state: slot tick and digit index, both cleared while disabled.
   always_comb begin
      tick_d  = tick_q;
      digit_d = digit_q;
      if (!enable) begin
         tick_d  = '0;
         digit_d = '0;
      end else begin
         tick_d = tick_q + 1'b1;
         if (&tick_q) begin
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
         end
      end
   end

   // Timebase registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_q  <= '0;
         digit_q <= '0;
      end else begin
         tick_q  <= tick_d;
         digit_q <= digit_d;
      end
   end

   // Frame snapshot of the display inputs; held while disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_value_q  <= '0;
         snap_dp_q     <= '0;
         snap_lz_q     <= 1'b0;
         snap_bright_q <= '0;
      end else if (snap_take) begin
         snap_value_q  <= value;
         snap_dp_q     <= dp_mask;
         snap_lz_q     <= blank_lz;
         snap_bright_q <= brightness;
      end
   end

   assign nibble = eff_value[4*digit_q +: 4];

   sseg_hex_encoder u_hex_encoder (
      .nibble   (nibble),
      .segments (hex_seg)
   );

   // Leading zero: every nibble from the current digit upward is zero.
   always_comb begin
      upper_nz = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i >= int'(digit_q) && eff_value[4*i +: 4] != 4'h0) begin
            upper_nz = 1'b1;
         end
      end
      lz_suppress = eff_lz && (digit_q != '0) && !upper_nz;
   end

   // PWM duty uses the top bits of the tick; the blank window hides ghosting.
   assign pwm_slice = tick_q[DIV_BITS-1 -: BRIGHT_W];
   assign lit       = enable && (tick_q >= BLANK_END) && (pwm_slice < eff_bright);

   // Active-high output image for the current counter state.
   always_comb begin
      sel_d  = '0;
      data_d = '0;
      if (lit) begin
         sel_d              = NUM_DIGITS'(1) << digit_q;
         data_d[6:0]        = lz_suppress ? SEG_OFF : hex_seg;
         data_d[SEG_DP_BIT] = eff_dp[digit_q];
      end
   end

   // Output register with polarity applied; reset drives the inactive level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q  <= SEL_OFF;
         data_q <= DATA_OFF;
      end else begin
         sel_q  <= sel_d ^ SEL_OFF;
         data_q <= data_d ^ DATA_OFF;
      end
   end

   assign sseg_sel  = sel_q;
   assign sseg_data = data_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: two instances (active-high and active-low outputs)
// driven in parallel and compared against a frame-level reference model.
module tb_sseg_scan_ctrl;

   localparam int ND    = 4;
   localparam int DIVB  = 6;
   localparam int BW    = 4;
   localparam int BLANK = 4;
   localparam int SLOT  = 64;
   localparam int FRAME = SLOT * ND;

   logic        clk;
   logic        rst;
   logic [15:0] value;
   logic [3:0]  dp_mask;
   logic        blank_lz;
   logic [3:0]  brightness;
   logic        enable;

   logic [3:0]  sseg_sel, sel_n;
   logic [7:0]  sseg_data, data_n;
   logic        frame_start, fs_n;

   int          n_checks = 0;
   int          n_errors = 0;

   // Reference model state: position within the frame and the latched frame inputs.
   int          m_pos;
   logic [15:0] m_value;
   logic [3:0]  m_dp;
   logic        m_lz;
   logic [3:0]  m_bright;
   logic [3:0]  exp_sel;
   logic [7:0]  exp_data;
   logic        exp_fs;

   logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   sseg_scan_ctrl #(
      .NUM_DIGITS     (ND),
      .DIV_BITS       (DIVB),
      .BRIGHT_W       (BW),
      .BLANK_TICKS    (BLANK),
      .SEL_ACTIVE_LOW (1'b0),
      .SEG_ACTIVE_LOW (1'b0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .value       (value),
      .dp_mask     (dp_mask),
      .blank_lz    (blank_lz),
      .brightness  (brightness),
      .enable      (enable),
      .sseg_sel    (sseg_sel),
      .sseg_data   (sseg_data),
      .frame_start (frame_start)
   );

   sseg_scan_ctrl #(
      .NUM_DIGITS     (ND),
      .DIV_BITS       (DIVB),
      .BRIGHT_W       (BW),
      .BLANK_TICKS    (BLANK),
      .SEL_ACTIVE_LOW (1'b1),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut_n (
      .clk         (clk),
      .rst         (rst),
      .value       (value),
      .dp_mask     (dp_mask),
      .blank_lz    (blank_lz),
      .brightness  (brightness),
      .enable      (enable),
      .sseg_sel    (sel_n),
      .sseg_data   (data_n),
      .frame_start (fs_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; the model predicts the outputs registered at this edge.
   task automatic step();
      int         tick, dig;
      logic [15:0] upper;
      if (!enable) begin
         m_pos    = 0;
         exp_sel  = '0;
         exp_data = '0;
      end else begin
         if (m_pos == 0) begin
            m_value  = value;
            m_dp     = dp_mask;
            m_lz     = blank_lz;
            m_bright = brightness;
         end
         tick     = m_pos % SLOT;
         dig      = m_pos / SLOT;
         exp_sel  = '0;
         exp_data = '0;
         if (tick >= BLANK && (tick / (SLOT / (1 << BW))) < int'(m_bright)) begin
            upper         = m_value >> (4 * dig);
            exp_sel       = 4'(1 << dig);
            exp_data[6:0] = (m_lz && dig > 0 && upper == 16'h0) ? 7'h00 : seg_tab[upper[3:0]];
            exp_data[7]   = m_dp[dig];
         end
         m_pos = (m_pos + 1) % FRAME;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      enable = 1'b0; value = 16'h1234; dp_mask = 4'h0; blank_lz = 1'b0; brightness = 4'hF;
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (sseg_sel !== 4'h0 || sseg_data !== 8'h00 || frame_start !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_pos got sel=%b data=%h fs=%b want 0000/00/0",
                  sseg_sel, sseg_data, frame_start);
      end
      n_checks++;
      if (sel_n !== 4'hF || data_n !== 8'hFF) begin
         n_errors++;
         $display("FAIL reset_neg got sel=%b data=%h want 1111/ff", sel_n, data_n);
      end
      enable = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (frame_start !== 1'b0 || sseg_sel !== 4'h0 || sel_n !== 4'hF) begin
         n_errors++;
         $display("FAIL reset_enabled got fs=%b sel=%b seln=%b want 0/0000/1111",
                  frame_start, sseg_sel, sel_n);
      end
      enable = 1'b0;
      rst    = 1'b0;
      m_pos  = 0; exp_sel = '0; exp_data = '0;
   endtask

   task automatic test_basic_scan();
      value = 16'h1234; brightness = 4'hF; dp_mask = 4'h0; blank_lz = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < FRAME + SLOT + 8; i++) begin
         #1;
         exp_fs = enable && (m_pos == 0);
         n_checks++;
         if (frame_start !== exp_fs || fs_n !== exp_fs) begin
            n_errors++;
            $display("FAIL basic_fs cyc=%0d got %b/%b want %b", i, frame_start, fs_n, exp_fs);
         end
         step();
         n_checks++;
         if (sseg_sel !== exp_sel || sseg_data !== exp_data ||
             sel_n !== ~exp_sel || data_n !== ~exp_data) begin
            n_errors++;
            $display("FAIL basic_out cyc=%0d got %b/%h %b/%h want %b/%h", i, sseg_sel,
                     sseg_data, sel_n, data_n, exp_sel, exp_data);
         end
      end
   endtask

   task automatic test_lz_dp();
      value = 16'h0050; blank_lz = 1'b1; dp_mask = 4'b0100; brightness = 4'hF;
      enable = 1'b0;
      for (int i = 0; i < FRAME + 2; i++) begin
         if (i == 1) enable = 1'b1;
         #1;
         exp_fs = enable && (m_pos == 0);
         n_checks++;
         if (frame_start !== exp_fs) begin
            n_errors++;
            $display("FAIL lz_fs cyc=%0d got %b want %b", i, frame_start, exp_fs);
         end
         step();
         n_checks++;
         if (sseg_sel !== exp_sel || sseg_data !== exp_data ||
             sel_n !== ~exp_sel || data_n !== ~exp_data) begin
            n_errors++;
            $display("FAIL lz_out cyc=%0d got %b/%h %b/%h want %b/%h", i, sseg_sel,
                     sseg_data, sel_n, data_n, exp_sel, exp_data);
         end
      end
   endtask

   task automatic test_brightness();
      value = 16'h8888; blank_lz = 1'b0; dp_mask = 4'hF;
      for (int b = 0; b < 3; b++) begin
         brightness = (b == 0) ? 4'd0 : (b == 1) ? 4'd8 : 4'd1;
         enable     = 1'b0;
         for (int i = 0; i < FRAME + 2; i++) begin
            if (i == 1) enable = 1'b1;
            #1;
            step();
            n_checks++;
            if (sseg_sel !== exp_sel || sseg_data !== exp_data ||
                sel_n !== ~exp_sel || data_n !== ~exp_data) begin
               n_errors++;
               $display("FAIL bright%0d cyc=%0d got %b/%h want %b/%h", brightness, i,
                        sseg_sel, sseg_data, exp_sel, exp_data);
            end
         end
      end
   endtask

   task automatic test_midframe();
      value = 16'h1111; brightness = 4'hF; dp_mask = 4'h0; blank_lz = 1'b0;
      enable = 1'b0;
      for (int i = 0; i < 2 * FRAME + 2; i++) begin
         if (i == 1) enable = 1'b1;
         if (i == 2 * SLOT + 10) value = 16'h2222;
         #1;
         exp_fs = enable && (m_pos == 0);
         n_checks++;
         if (frame_start !== exp_fs) begin
            n_errors++;
            $display("FAIL mid_fs cyc=%0d got %b want %b", i, frame_start, exp_fs);
         end
         step();
         n_checks++;
         if (sseg_sel !== exp_sel || sseg_data !== exp_data) begin
            n_errors++;
            $display("FAIL mid_out cyc=%0d got %b/%h want %b/%h", i, sseg_sel, sseg_data,
                     exp_sel, exp_data);
         end
      end
   endtask

   task automatic test_enable_gap();
      value = 16'h9A7C; brightness = 4'hC; dp_mask = 4'b1010; blank_lz = 1'b0;
      for (int i = 0; i < FRAME + 120; i++) begin
         if (i == SLOT + 20) enable = 1'b0;
         if (i == SLOT + 30) enable = 1'b1;
         #1;
         exp_fs = enable && (m_pos == 0);
         n_checks++;
         if (frame_start !== exp_fs || fs_n !== exp_fs) begin
            n_errors++;
            $display("FAIL gap_fs cyc=%0d got %b want %b", i, frame_start, exp_fs);
         end
         step();
         n_checks++;
         if (sseg_sel !== exp_sel || sseg_data !== exp_data ||
             sel_n !== ~exp_sel || data_n !== ~exp_data) begin
            n_errors++;
            $display("FAIL gap_out cyc=%0d got %b/%h want %b/%h", i, sseg_sel, sseg_data,
                     exp_sel, exp_data);
         end
      end
   endtask

   task automatic test_reset_midframe();
      value = 16'h00F3; brightness = 4'hF; dp_mask = 4'b0001; blank_lz = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         step();
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (sseg_sel !== 4'h0 || sseg_data !== 8'h00 || sel_n !== 4'hF || data_n !== 8'hFF ||
          frame_start !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_mid got %b/%h %b/%h fs=%b want 0000/00 1111/ff 0", sseg_sel,
                  sseg_data, sel_n, data_n, frame_start);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_pos = 0; exp_sel = '0; exp_data = '0;
      for (int i = 0; i < FRAME + 4; i++) begin
         #1;
         exp_fs = enable && (m_pos == 0);
         n_checks++;
         if (frame_start !== exp_fs) begin
            n_errors++;
            $display("FAIL rst_fs cyc=%0d got %b want %b", i, frame_start, exp_fs);
         end
         step();
         n_checks++;
         if (sseg_sel !== exp_sel || sseg_data !== exp_data ||
             sel_n !== ~exp_sel || data_n !== ~exp_data) begin
            n_errors++;
            $display("FAIL rst_out cyc=%0d got %b/%h want %b/%h", i, sseg_sel, sseg_data,
                     exp_sel, exp_data);
         end
      end
   endtask

   task automatic test_random();
      int sh;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            sh         = 4 * int'($urandom_range(0, 4));
            value      = 16'($urandom) & (16'hFFFF >> sh);
            dp_mask    = 4'($urandom);
            blank_lz   = 1'($urandom);
            brightness = 4'($urandom);
         end
         if (enable) begin
            if ($urandom_range(0, 299) == 0) enable = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            enable = 1'b1;
         end
         #1;
         exp_fs = enable && (m_pos == 0);
         n_checks++;
         if (frame_start !== exp_fs || fs_n !== exp_fs) begin
            n_errors++;
            $display("FAIL rnd_fs cyc=%0d got %b/%b want %b", i, frame_start, fs_n, exp_fs);
         end
         step();
         n_checks++;
         if (sseg_sel !== exp_sel || sseg_data !== exp_data ||
             sel_n !== ~exp_sel || data_n !== ~exp_data) begin
            n_errors++;
            $display("FAIL rnd_out cyc=%0d got %b/%h %b/%h want %b/%h", i, sseg_sel,
                     sseg_data, sel_n, data_n, exp_sel, exp_data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_scan();
      test_lz_dp();
      test_brightness();
      test_midframe();
      test_enable_gap();
      test_reset_midframe();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Parametrised N-digit multiplexed seven-segment scan controller. It is the successor to the fixed 4-digit scanner. It generates all timing from a clock-enable prescaler, so no derived clocks are used. It adds ghost-suppression blanking, PWM brightness, per-digit decimal points, leading-zero suppression, tear-free frame latching and selectable output polarity. It sits between application logic (BCD/hex value source) and the board's digit-select and segment pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
DIV_BITS, 16, slot length = 2^DIV_BITS clk cycles per digit
BRIGHT_W, 4, brightness input width; must be <= DIV_BITS
BLANK_TICKS, 64, dark cycles at the start of each slot (ghost suppression); must be < 2^DIV_BITS
SEL_ACTIVE_LOW, 0, 1 = digit selects active-low
SEG_ACTIVE_LOW, 0, 1 = segment/dp lines active-low

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
value  in  4*NUM_DIGITS  hex nibbles; nibble i = value[4i+3:4i] drives digit i (digit 0 = least significant)
dp_mask  in  NUM_DIGITS  decimal point enable per digit
blank_lz  in  1  1 = suppress leading zeros
brightness  in  BRIGHT_W  0 = off, 2^BRIGHT_W-1 = maximum
enable  in  1  0 = display dark, scan halted
sseg_sel  out  NUM_DIGITS  one-hot digit select (polarity per SEL_ACTIVE_LOW)
sseg_data  out  8  bit0..6 = segments a..g, bit7 = dp (polarity per SEG_ACTIVE_LOW)
frame_start  out  1  one-cycle pulse when the snapshot is taken

Behaviour:
- Reset (async, rst=1): tick counter=0, digit index=0, snapshot registers=0, frame_start=0; sseg_sel and sseg_data at inactive level (all off).
- Tick counter: DIV_BITS wide, +1 per clk while enable=1. Wraps 2^DIV_BITS-1 -> 0 and advances the digit index. The digit index wraps NUM_DIGITS-1 -> 0; it is not a power-of-two wrap.
- Snapshot: in any cycle with enable=1, tick=0 and digit=0, value/dp_mask/blank_lz/brightness are registered and frame_start=1 for that cycle. This also fires on the first enabled cycle after reset. Input changes mid-frame never appear until the next frame.
- Lit condition for the current slot: tick >= BLANK_TICKS AND tick[DIV_BITS-1 -: BRIGHT_W] < snapshot brightness.
  - brightness=0 gives never lit.
  - max brightness gives (2^BRIGHT_W-1)/2^BRIGHT_W of the slot, minus the blank window.
- Outputs are registered, with 1 cycle latency from counter state:
  - sseg_sel = one-hot(digit) when lit, else all inactive.
  - sseg_data = encoded nibble of the current digit plus dp_mask[digit] when lit, else all inactive.
  - Polarity inversion is applied at the output register.
- Leading-zero suppression: when snapshot blank_lz=1 and digit i>0 and all snapshot nibbles i..NUM_DIGITS-1 are 0, segments a..g are off for digit i. dp still follows dp_mask, and sseg_sel is still driven. Digit 0 is never suppressed.
- enable=0: tick and digit are synchronously cleared to 0, outputs go inactive on the next cycle, frame_start=0, and the snapshot is held. On return to 1, a new frame starts immediately with a fresh snapshot.
- Reset mid-frame: outputs go inactive immediately (async); the scan restarts at digit 0 after release.
- NUM_DIGITS=1: the digit index is constant 0, and every slot wrap is a frame start.

Decomposition:
- Package sseg_pkg: 7-bit segment pattern constants for 0-F, SEG_OFF constant, and bit-position constants for a..g/dp.
- Sub-module sseg_hex_encoder: combinational 4-bit nibble -> 7-bit active-high pattern. Polarity is handled only in sseg_scan_ctrl.
- Leading-zero detection and PWM compare stay inline.

Test Plan (NUM_DIGITS=4, DIV_BITS=6, BRIGHT_W=4, BLANK_TICKS=4, both polarities 0):
1. Reset then value=16'h1234, brightness=15, enable=1 -> frame_start at first cycle; digit 0 lit cycles 4..59 of its slot with sseg_data=8'h66 ('4'); sel walks 0001, 0010, 0100, 1000, then back to 0001 every 64 cycles.
2. value=16'h0050, blank_lz=1, dp_mask=4'b0100 -> digit 3 segments off; digit 2 shows 8'h80 (dp only, sel active); digit 1 shows '5' (8'h6D); digit 0 shows '0' (8'h3F).
3. brightness=0 -> sseg_sel never active; brightness=8 -> each slot lit for tick 4..31 (28 cycles), dark for 32..63.
4. Change value mid-frame from 16'h1111 to 16'h2222 at digit 2 -> digits 2,3 still show '1' until next frame_start, then all show '2'.
5. Deassert enable for 10 cycles mid-slot -> outputs inactive from next cycle; on re-enable, frame_start pulses and digit 0 scans from tick 0.
6. SEL_ACTIVE_LOW=1, SEG_ACTIVE_LOW=1 with value=0 -> during reset sel=4'hF and data=8'hFF; when digit 0 is lit, sel=4'b1110 and data=8'hC0.
